// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and
// the datapath mux/ALU select values driven by the controller.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_ADDI_EXEC,
        S_ADDI_WB,
        S_BRANCH,
        S_JUMP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        B_RT      = 2'b00,
        B_FOUR    = 2'b01,
        B_IMM     = 2'b10,
        B_IMM_SH2 = 2'b11
    } alu_b_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory access has been stalled; flags the cycle that uses up
// the last allowed wait so the controller can abandon the access.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Depends only on the register so the controller's decode has no loop through it.
    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with the unified memory port and abandons accesses that stall too long.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic        illegal_nxt;
    logic        bus_err_nxt;
    logic        retire;
    logic        expired;
    logic        wait_clr;
    logic        wait_en;

    // funct is decoded by the ALU control block, not by this sequencer.
    logic unused_funct;
    assign unused_funct = ^funct;

    assign wait_en  = mem_req & ~mem_ready;
    assign wait_clr = ~mem_req | mem_ready | expired;

    mem_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clr),
        .enable  (wait_en),
        .expired (expired)
    );

    // Next-state and output decode; everything is forced low while rst is high.
    always_comb begin
        state_nxt   = state;
        illegal_nxt = 1'b0;
        bus_err_nxt = 1'b0;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_source   = PC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = B_RT;
        alu_op      = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;

        if (!rst) begin
            case (state)
                S_FETCH: begin
                    alu_src_b = B_FOUR;
                    // Request stays dropped for the cycle that reports a timeout.
                    if (!bus_error) begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_write  = 1'b1;
                            pc_write  = 1'b1;
                            state_nxt = S_DECODE;
                        end else if (expired) begin
                            bus_err_nxt = 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    alu_src_b = B_IMM_SH2;
                    case (opcode)
                        OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                        OP_RTYPE:     state_nxt = S_R_EXEC;
                        OP_BEQ:       state_nxt = S_BRANCH;
                        OP_ADDI:      state_nxt = S_ADDI_EXEC;
                        OP_J:         state_nxt = S_JUMP;
                        default: begin
                            illegal_nxt = 1'b1;
                            state_nxt   = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = B_IMM;
                    state_nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_nxt = S_MEM_WB;
                    end else if (expired) begin
                        bus_err_nxt = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else if (expired) begin
                        bus_err_nxt = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = B_RT;
                    alu_op    = ALU_FUNCT;
                    state_nxt = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = B_IMM;
                    state_nxt = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = B_RT;
                    alu_op    = ALU_SUB;
                    pc_source = PC_ALUOUT;
                    pc_write  = zero;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_JUMP: begin
                    pc_source = PC_JUMP;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            illegal_op <= 1'b0;
            bus_error  <= 1'b0;
            retired    <= '0;
        end else begin
            state      <= state_nxt;
            illegal_op <= illegal_nxt;
            bus_error  <= bus_err_nxt;
            if (retire) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, memory stalls,
// timeout, illegal opcode, async reset and retired-counter wrap against hand-written vectors.
module tb_multicycle_control;

    localparam int unsigned TO    = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal_op;
    logic             bus_error;
    logic [CNT_W-1:0] retired;

    int n_pass;
    int n_total;

    multicycle_control #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .retired    (retired)
    );

    logic [16:0] obs;
    assign obs = {mem_req, mem_write, iord, ir_write, pc_write, pc_source, alu_src_a,
                  alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal_op, bus_error};

    // Field order: req wr iord irw pcw pcs asa asb aop rw rd m2r ill berr
    localparam logic [16:0] V_ZERO      = '0;
    localparam logic [16:0] V_FETCH     = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_FETCH_RDY = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_FETCH_ILL = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [16:0] V_FETCH_BE  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1};
    localparam logic [16:0] V_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_ADDR      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_MRD       = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_MWB       = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0};
    localparam logic [16:0] V_MWR       = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_REX       = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_RWB       = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_AWB       = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_BR_T      = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_BR_NT     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_JMP       = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Check the control vector mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [16:0] exp);
        #2;
        check(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ret(input string tag, input int unsigned exp);
        check(tag, 32'(retired), exp);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(obs), 32'(V_ZERO));
        chk_ret("reset_retired", 0);
        rst = 1'b0;

        // R-type add
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        cyc("r_fetch", V_FETCH_RDY);
        cyc("r_decode", V_DECODE);
        cyc("r_exec", V_REX);
        cyc("r_wb", V_RWB);
        chk_ret("r_retired", 1);

        // LW with three stalled cycles in MEM_READ
        opcode = 6'b100011;
        cyc("lw_fetch", V_FETCH_RDY);
        mem_ready = 1'b0;
        cyc("lw_decode", V_DECODE);
        cyc("lw_addr", V_ADDR);
        cyc("lw_rd_wait1", V_MRD);
        cyc("lw_rd_wait2", V_MRD);
        cyc("lw_rd_wait3", V_MRD);
        mem_ready = 1'b1;
        cyc("lw_rd_done", V_MRD);
        cyc("lw_wb", V_MWB);
        chk_ret("lw_retired", 2);

        // SW
        opcode = 6'b101011;
        cyc("sw_fetch", V_FETCH_RDY);
        cyc("sw_decode", V_DECODE);
        cyc("sw_addr", V_ADDR);
        cyc("sw_write", V_MWR);
        chk_ret("sw_retired", 3);

        // BEQ taken / not taken
        opcode = 6'b000100; zero = 1'b1;
        cyc("beq_t_fetch", V_FETCH_RDY);
        cyc("beq_t_decode", V_DECODE);
        cyc("beq_taken", V_BR_T);
        chk_ret("beq_t_retired", 4);
        zero = 1'b0;
        cyc("beq_n_fetch", V_FETCH_RDY);
        cyc("beq_n_decode", V_DECODE);
        cyc("beq_not_taken", V_BR_NT);
        chk_ret("beq_n_retired", 5);

        // ADDI
        opcode = 6'b001000;
        cyc("addi_fetch", V_FETCH_RDY);
        cyc("addi_decode", V_DECODE);
        cyc("addi_exec", V_ADDR);
        cyc("addi_wb", V_AWB);
        chk_ret("addi_retired", 6);

        // J
        opcode = 6'b000010;
        cyc("j_fetch", V_FETCH_RDY);
        cyc("j_decode", V_DECODE);
        cyc("j_jump", V_JMP);
        chk_ret("j_retired", 7);

        // Illegal opcode: single pulse, no retire
        opcode = 6'b111111;
        cyc("ill_fetch", V_FETCH_RDY);
        mem_ready = 1'b0;
        cyc("ill_decode", V_DECODE);
        cyc("ill_pulse", V_FETCH_ILL);
        chk_ret("ill_retired", 7);
        opcode = 6'b000010; mem_ready = 1'b1;
        cyc("ill_cleared", V_FETCH_RDY);
        cyc("ill_j_decode", V_DECODE);
        cyc("ill_j_jump", V_JMP);
        chk_ret("ill_j_retired", 8);

        // Fetch timeout after TO stalled cycles
        mem_ready = 1'b0;
        cyc("to_wait1", V_FETCH);
        cyc("to_wait2", V_FETCH);
        cyc("to_wait3", V_FETCH);
        cyc("to_wait4", V_FETCH);
        cyc("to_bus_error", V_FETCH_BE);
        cyc("to_refetch", V_FETCH);
        chk_ret("to_retired", 8);

        // Async reset while a store is stalled
        opcode = 6'b101011; mem_ready = 1'b1;
        cyc("rs_fetch", V_FETCH_RDY);
        mem_ready = 1'b0;
        cyc("rs_decode", V_DECODE);
        cyc("rs_addr", V_ADDR);
        cyc("rs_write", V_MWR);
        rst = 1'b1;
        #1;
        check("rs_async_outputs", 32'(obs), 32'(V_ZERO));
        chk_ret("rs_async_retired", 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("rs_post_fetch", V_FETCH);
        chk_ret("rs_post_retired", 0);

        // Retired counter wrap (CNT_W=4) using 3-cycle jumps
        opcode = 6'b000010; mem_ready = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        chk_ret("wrap_15", 15);
        repeat (3) @(posedge clk);
        #1;
        chk_ret("wrap_0", 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
